// File: rtl/multicycle_controlpath.sv
// rtl/multicycle_controlpath.sv - sequenced FSM control unit for the multicycle RV32I datapath
module multicycle_controlpath #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int BRANCH_FULL   = 1,
    parameter int ALUCTRL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          Instr,
    input  logic                 Zero,
    input  logic                 Negative,
    input  logic                 Carry,
    input  logic                 Overflow,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR_TGT,
        S_JALR_LINK, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 mem_ok;
    logic                 br_legal;
    logic                 br_taken;
    logic [ALUCTRL_W-1:0] alu_op;
    logic                 unused_instr;

    assign opcode       = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign mem_ok       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (Instr[5] && Instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = Instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // Carry is the subtractor's no-borrow flag, so unsigned less-than is !Carry.
    always_comb begin
        br_taken = 1'b0;
        br_legal = (BRANCH_FULL != 0) || (funct3 == 3'b000);
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = Negative ^ Overflow;
            3'b101:  br_taken = !(Negative ^ Overflow);
            3'b110:  br_taken = !Carry;
            3'b111:  br_taken = Carry;
            default: br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECUTER;
                    7'b0010011:             state_d = S_EXECUTEI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR_TGT;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_AUIPC;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEMADR:    state_d = Instr[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   if (mem_ok) state_d = S_MEMWB;
            S_MEMWB:     state_d = S_FETCH;
            S_MEMWRITE:  if (mem_ok) state_d = S_FETCH;
            S_EXECUTER:  state_d = S_ALUWB;
            S_EXECUTEI:  state_d = S_ALUWB;
            S_ALUWB:     state_d = S_FETCH;
            S_BRANCH:    state_d = br_legal ? S_FETCH : S_TRAP;
            S_JAL:       state_d = S_ALUWB;
            S_JALR_TGT:  state_d = S_JALR_LINK;
            S_JALR_LINK: state_d = S_ALUWB;
            S_LUI:       state_d = S_ALUWB;
            S_AUIPC:     state_d = S_ALUWB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_ok;
                PCWrite   = mem_ok;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = Instr[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = br_legal & br_taken;
            end
            S_JAL, S_JALR_LINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR_TGT: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
            end
            default: ;
        endcase
        // The async reset already parks the state in FETCH; this keeps FETCH's drives off the bus too.
        if (!rst_n) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controlpath.sv
// tb/tb_multicycle_controlpath.sv - scoreboard bench for multicycle_controlpath
module tb_multicycle_controlpath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic        Zero = 1'b0, Negative = 1'b0, Carry = 1'b0, Overflow = 1'b0;
    logic        mem_ready = 1'b0;

    logic       pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a;
    logic [1:0] rs_a, sa_a, sb_a;
    logic [2:0] imm_a;
    logic [3:0] alu_a;
    logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b;
    logic [1:0] rs_b, sa_b, sb_b;
    logic [2:0] imm_b;
    logic [3:0] alu_b;
    logic [18:0] got_a, got_b;

    assign got_a = {pcw_a, adr_a, mw_a, irw_a, rw_a, rs_a, sa_a, sb_a, imm_a, alu_a, ill_a};
    assign got_b = {pcw_b, adr_b, mw_b, irw_b, rw_b, rs_b, sa_b, sb_b, imm_b, alu_b, ill_b};

    multicycle_controlpath dut (
        .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .Negative(Negative),
        .Carry(Carry), .Overflow(Overflow), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a), .RegWrite(rw_a),
        .ResultSrc(rs_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ImmSrc(imm_a),
        .ALUControl(alu_a), .illegal(ill_a)
    );

    multicycle_controlpath #(.BRANCH_FULL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .Negative(Negative),
        .Carry(Carry), .Overflow(Overflow), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b), .RegWrite(rw_b),
        .ResultSrc(rs_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ImmSrc(imm_b),
        .ALUControl(alu_b), .illegal(ill_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic [3:0]  fl;
        logic [18:0] e;
    } step_t;

    int checks = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    // Expected output vector: {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal}
    function automatic logic [18:0] ev(input logic pcw, adr, mw, irw, rw, input logic [1:0] rs, sa, sb,
                                       input logic [2:0] imm, input logic [3:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [18:0] x_fetch(input logic r);    return ev(r,0,0,r,0,2'b10,2'b00,2'b10,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_decode();                return ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b010,4'd0,0); endfunction
    function automatic logic [18:0] x_memadr(input logic st);  return ev(0,0,0,0,0,2'b00,2'b10,2'b01,st ? 3'b001 : 3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_memread();               return ev(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_memwb();                 return ev(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_memwrite();              return ev(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_exec(input logic isi, input logic [3:0] op);
        return ev(0,0,0,0,0,2'b00,2'b10,isi ? 2'b01 : 2'b00,3'b000,op,0);
    endfunction
    function automatic logic [18:0] x_aluwb();                 return ev(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_branch(input logic pcw); return ev(pcw,0,0,0,0,2'b00,2'b10,2'b00,3'b000,4'd1,0); endfunction
    function automatic logic [18:0] x_link();                  return ev(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_jalr_tgt();              return ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,4'd0,0); endfunction
    function automatic logic [18:0] x_lui();                   return ev(0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,4'd0,0); endfunction
    function automatic logic [18:0] x_auipc();                 return ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,4'd0,0); endfunction
    function automatic logic [18:0] x_trap();                  return ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'd0,1); endfunction

    function automatic step_t st(input logic [31:0] i, input logic r, input logic [3:0] f, input logic [18:0] e);
        step_t s;
        s.instr = i; s.rdy = r; s.fl = f; s.e = e;
        return s;
    endfunction

    task automatic drive_step(input step_t s);
        @(negedge clk);
        Instr     = s.instr;
        mem_ready = s.rdy;
        {Zero, Negative, Carry, Overflow} = s.fl;
        exp_q.push_back(s.e);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        step_t s[$];
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            Instr = $urandom; mem_ready = 1'b1; {Zero, Negative, Carry, Overflow} = 4'($urandom);
            exp_q.push_back(19'd0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (got_a !== e) begin failures++; $display("FAIL reset_outs[%0d] got=%h exp=%h", i, got_a, e); end
            checks++;
            if (got_b !== e) begin failures++; $display("FAIL reset_outs_b[%0d] got=%h exp=%h", i, got_b, e); end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s.push_back(st(32'h002081B3, 0, 4'h0, x_fetch(0)));
        s.push_back(st(32'h002081B3, 1, 4'h0, x_fetch(1)));
        s.push_back(st(32'h002081B3, 0, 4'h0, x_decode()));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL reset_release[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    task automatic test_alu_ops();
        logic [18:0] e;
        step_t s[$];
        logic [31:0] ins [7] = '{32'h002081B3, 32'h402081B3, 32'h4030D193, 32'h0020B1B3,
                                 32'hC0008193, 32'h0020F1B3, 32'h0020D1B3};
        logic [3:0]  op  [7] = '{4'd0, 4'd1, 4'd9, 4'd6, 4'd0, 4'd2, 4'd8};
        logic        isi [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            s.push_back(st(ins[k], 1, 4'h0, x_fetch(1)));
            s.push_back(st(ins[k], 0, 4'h0, x_decode()));
            s.push_back(st(ins[k], 0, 4'h0, x_exec(isi[k], op[k])));
            s.push_back(st(ins[k], 0, 4'h0, x_aluwb()));
        end
        s.push_back(st(32'h0, 0, 4'h0, x_fetch(0)));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL alu_ops[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    task automatic test_load();
        logic [18:0] e;
        step_t s[$];
        logic [31:0] lw = 32'h0000A283;
        apply_reset();
        s.push_back(st(lw, 0, 4'h0, x_fetch(0)));
        s.push_back(st(lw, 0, 4'h0, x_fetch(0)));
        s.push_back(st(lw, 1, 4'h0, x_fetch(1)));
        s.push_back(st(lw, 0, 4'h0, x_decode()));
        s.push_back(st(lw, 0, 4'h0, x_memadr(0)));
        s.push_back(st(lw, 0, 4'h0, x_memread()));
        s.push_back(st(lw, 0, 4'h0, x_memread()));
        s.push_back(st(lw, 1, 4'h0, x_memread()));
        s.push_back(st(lw, 0, 4'h0, x_memwb()));
        s.push_back(st(lw, 0, 4'h0, x_fetch(0)));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL load[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    task automatic test_store_reset();
        logic [18:0] e;
        step_t s[$];
        step_t r[$];
        logic [31:0] sw = 32'h0020A223;
        apply_reset();
        s.push_back(st(sw, 1, 4'h0, x_fetch(1)));
        s.push_back(st(sw, 0, 4'h0, x_decode()));
        s.push_back(st(sw, 0, 4'h0, x_memadr(1)));
        s.push_back(st(sw, 0, 4'h0, x_memwrite()));
        s.push_back(st(sw, 0, 4'h0, x_memwrite()));
        s.push_back(st(sw, 0, 4'h0, x_memwrite()));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL store[%0d] got=%h exp=%h", i, got_a, e); end
        end
        #2;
        rst_n = 1'b0;
        exp_q.push_back(19'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (got_a !== e) begin failures++; $display("FAIL store_async_reset got=%h exp=%h", got_a, e); end
        @(negedge clk);
        rst_n = 1'b1;
        r.push_back(st(sw, 0, 4'h0, x_fetch(0)));
        r.push_back(st(sw, 0, 4'h0, x_fetch(0)));
        r.push_back(st(sw, 1, 4'h0, x_fetch(1)));
        r.push_back(st(sw, 0, 4'h0, x_decode()));
        foreach (r[i]) begin
            drive_step(r[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL store_after_reset[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    task automatic test_branch();
        logic [18:0] e;
        step_t s[$];
        logic [31:0] br [4] = '{32'h0020E463, 32'h0020E463, 32'h0020D463, 32'h00208463};
        logic [3:0]  fl [4] = '{4'b0000, 4'b0010, 4'b0101, 4'b0000};
        logic        tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(br[k], 1, 4'h0, x_fetch(1)));
            s.push_back(st(br[k], 0, 4'h0, x_decode()));
            s.push_back(st(br[k], 0, fl[k], x_branch(tk[k])));
        end
        s.push_back(st(32'h0, 0, 4'h0, x_fetch(0)));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL branch[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    task automatic test_branch_lite();
        logic [18:0] e, eb;
        step_t s[$];
        logic [18:0] exp_b_q[$];
        logic [31:0] bne = 32'h00209463;
        apply_reset();
        s.push_back(st(bne, 1, 4'h0, x_fetch(1)));  exp_b_q.push_back(x_fetch(1));
        s.push_back(st(bne, 0, 4'h0, x_decode()));  exp_b_q.push_back(x_decode());
        s.push_back(st(bne, 0, 4'h0, x_branch(1))); exp_b_q.push_back(x_branch(0));
        s.push_back(st(bne, 1, 4'h0, x_fetch(1)));  exp_b_q.push_back(x_trap());
        s.push_back(st(bne, 0, 4'h0, x_decode()));  exp_b_q.push_back(x_trap());
        s.push_back(st(bne, 1, 4'h0, x_branch(1))); exp_b_q.push_back(x_trap());
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e  = exp_q.pop_front();
            eb = exp_b_q.pop_front();
            checks++;
            if (got_a !== e) begin failures++; $display("FAIL bne_full[%0d] got=%h exp=%h", i, got_a, e); end
            checks++;
            if (got_b !== eb) begin failures++; $display("FAIL bne_beqonly[%0d] got=%h exp=%h", i, got_b, eb); end
        end
    endtask

    task automatic test_trap();
        logic [18:0] e;
        step_t s[$];
        apply_reset();
        s.push_back(st(32'h0, 1, 4'h0, x_fetch(1)));
        s.push_back(st(32'h0, 0, 4'h0, x_decode()));
        s.push_back(st(32'h0, 0, 4'h0, x_trap()));
        s.push_back(st(32'h0, 1, 4'hF, x_trap()));
        s.push_back(st(32'h002081B3, 1, 4'h0, x_trap()));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL trap[%0d] got=%h exp=%h", i, got_a, e); end
        end
        apply_reset();
        s.delete();
        s.push_back(st(32'h0020A463, 0, 4'h0, x_fetch(0)));
        s.push_back(st(32'h0020A463, 1, 4'h0, x_fetch(1)));
        s.push_back(st(32'h0020A463, 0, 4'h0, x_decode()));
        s.push_back(st(32'h0020A463, 0, 4'b1000, x_branch(0)));
        s.push_back(st(32'h0020A463, 1, 4'h0, x_trap()));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL trap_f3_010[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    task automatic test_jumps();
        logic [18:0] e;
        step_t s[$];
        logic [31:0] jalr = 32'h008280E7, jal = 32'h008000EF, lui = 32'h123450B7, auipc = 32'h12345097;
        apply_reset();
        s.push_back(st(jalr, 1, 4'h0, x_fetch(1)));
        s.push_back(st(jalr, 0, 4'h0, x_decode()));
        s.push_back(st(jalr, 0, 4'h0, x_jalr_tgt()));
        s.push_back(st(jalr, 0, 4'h0, x_link()));
        s.push_back(st(jalr, 0, 4'h0, x_aluwb()));
        s.push_back(st(jal, 1, 4'h0, x_fetch(1)));
        s.push_back(st(jal, 0, 4'h0, x_decode()));
        s.push_back(st(jal, 0, 4'h0, x_link()));
        s.push_back(st(jal, 0, 4'h0, x_aluwb()));
        s.push_back(st(lui, 1, 4'h0, x_fetch(1)));
        s.push_back(st(lui, 0, 4'h0, x_decode()));
        s.push_back(st(lui, 0, 4'h0, x_lui()));
        s.push_back(st(lui, 0, 4'h0, x_aluwb()));
        s.push_back(st(auipc, 1, 4'h0, x_fetch(1)));
        s.push_back(st(auipc, 0, 4'h0, x_decode()));
        s.push_back(st(auipc, 0, 4'h0, x_auipc()));
        s.push_back(st(auipc, 0, 4'h0, x_aluwb()));
        s.push_back(st(auipc, 0, 4'h0, x_fetch(0)));
        foreach (s[i]) begin
            drive_step(s[i]); #1;
            e = exp_q.pop_front(); checks++;
            if (got_a !== e) begin failures++; $display("FAIL jumps[%0d] got=%h exp=%h", i, got_a, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_load();
        test_store_reset();
        test_branch();
        test_branch_lite();
        test_trap();
        test_jumps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
